// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan driver.
package hub75_pkg;

    localparam int PANEL_COLS      = 64;
    localparam int PANEL_ROWS_HALF = 32;
    localparam int BCM_PLANES      = 4;

    // Field widths of the memory read address and the panel row select.
    localparam int COL_W   = 6;
    localparam int ROW_W   = 5;
    localparam int PLANE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        BLANK
    } scan_state_t;

    // One pixel pair: upper-half and lower-half colour bits shifted together.
    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } rgb_pair_t;

endpackage

// File: rtl/hub75_scan_driver_bcm_timer.sv
// Loadable down-counter timing the lit period of one BCM bit-plane.
// done_o is high in the last counted clock, so a load of N followed by
// waiting for done_o spans exactly N clocks.
module bcm_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    // Load on request, otherwise count down and park at zero.
    // NOTE: clocked state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: walks rows and BCM bit-planes, fetches pixel bits from
// the pixel memory and shifts them into the panel, then latches and lights
// each plane for BASE_CYCLES << plane clocks. Panel pins are registered from
// the action taken in each state, so they trail the state register by one clock.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS        = PANEL_COLS,
    parameter int ROWS_HALF   = PANEL_ROWS_HALF,
    parameter int PLANES      = BCM_PLANES,
    parameter int BASE_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [COL_W-1:0]   col_addr,
    output logic [ROW_W-1:0]   row_addr,
    output logic [PLANE_W-1:0] bcm_phase,
    input  logic               mem_r1,
    input  logic               mem_g1,
    input  logic               mem_b1,
    input  logic               mem_r2,
    input  logic               mem_g2,
    input  logic               mem_b2,
    output logic               panel_r1,
    output logic               panel_g1,
    output logic               panel_b1,
    output logic               panel_r2,
    output logic               panel_g2,
    output logic               panel_b2,
    output logic               panel_clk,
    output logic               panel_lat,
    output logic               panel_oe_n,
    output logic [ROW_W-1:0]   panel_addr,
    output logic               frame_start
);

    localparam int SUB_W  = $clog2(2 * COLS + 1);
    localparam int DISP_W = $clog2((BASE_CYCLES << (PLANES - 1)) + 1);

    localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(2 * COLS);
    localparam logic [SUB_W-1:0]   SUB_ONE    = SUB_W'(1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS_HALF - 1);
    localparam logic [ROW_W-1:0]   ROW_ONE    = ROW_W'(1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);
    localparam logic [PLANE_W-1:0] PLANE_ONE  = PLANE_W'(1);

    scan_state_t        state_q;
    logic [SUB_W-1:0]   s_q;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic               row_wrap;
    rgb_pair_t          pix_q;
    logic               panel_clk_q, panel_lat_q, panel_oe_n_q, frame_start_q;
    logic [ROW_W-1:0]   panel_addr_q;
    logic               disp_done;

    rgb_pair_t mem_pix;
    assign mem_pix = '{r1: mem_r1, g1: mem_g1, b1: mem_b1,
                       r2: mem_r2, g2: mem_g2, b2: mem_b2};

    // Memory read address: two clocks per column, last column held on the final step.
    assign col_addr  = (s_q == SUB_LAST) ? COL_W'(COLS - 1) : COL_W'(s_q >> 1);
    assign row_addr  = row_q;
    assign bcm_phase = plane_q;

    // Plane/row advance applied when a plane finishes its blanking clock.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        plane_d  = plane_q + PLANE_ONE;
        row_d    = row_q;
        row_wrap = 1'b0;
        if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            if (row_q == ROW_LAST) begin
                row_d    = '0;
                row_wrap = 1'b1;
            end else begin
                row_d = row_q + ROW_ONE;
            end
        end
    end

    bcm_timer #(
        .W (DISP_W)
    ) u_bcm_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (state_q == LATCH),
        .value_i (DISP_W'(BASE_CYCLES) << plane_q),
        .done_o  (disp_done)
    );

    // Scan FSM with registered panel outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            s_q           <= '0;
            row_q         <= '0;
            plane_q       <= '0;
            pix_q         <= '0;
            panel_clk_q   <= 1'b0;
            panel_lat_q   <= 1'b0;
            panel_oe_n_q  <= 1'b1;
            panel_addr_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            panel_lat_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    panel_oe_n_q <= 1'b1;
                    panel_clk_q  <= 1'b0;
                    if (enable) begin
                        state_q       <= SHIFT;
                        s_q           <= '0;
                        row_q         <= '0;
                        plane_q       <= '0;
                        frame_start_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    panel_oe_n_q <= 1'b1;
                    if (s_q[0]) begin
                        // Memory data for column s>>1 arrives one clock after its address.
                        pix_q       <= mem_pix;
                        panel_clk_q <= 1'b0;
                    end else if (s_q != '0) begin
                        panel_clk_q <= 1'b1;
                    end
                    if (s_q == SUB_LAST) begin
                        state_q <= LATCH;
                        s_q     <= '0;
                    end else begin
                        s_q <= s_q + SUB_ONE;
                    end
                end
                LATCH: begin
                    panel_lat_q  <= 1'b1;
                    panel_clk_q  <= 1'b0;
                    panel_oe_n_q <= 1'b1;
                    panel_addr_q <= row_q;
                    state_q      <= DISPLAY;
                end
                DISPLAY: begin
                    panel_oe_n_q <= 1'b0;
                    panel_clk_q  <= 1'b0;
                    if (disp_done) begin
                        state_q <= BLANK;
                    end
                end
                BLANK: begin
                    panel_oe_n_q <= 1'b1;
                    panel_clk_q  <= 1'b0;
                    plane_q      <= plane_d;
                    row_q        <= row_d;
                    if (enable) begin
                        state_q       <= SHIFT;
                        frame_start_q <= row_wrap;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign panel_r1    = pix_q.r1;
    assign panel_g1    = pix_q.g1;
    assign panel_b1    = pix_q.b1;
    assign panel_r2    = pix_q.r2;
    assign panel_g2    = pix_q.g2;
    assign panel_b2    = pix_q.b2;
    assign panel_clk   = panel_clk_q;
    assign panel_lat   = panel_lat_q;
    assign panel_oe_n  = panel_oe_n_q;
    assign panel_addr  = panel_addr_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver at BASE_CYCLES = 4.
// The memory model returns the parity of the column address on all six lines.
module tb_hub75_scan_driver;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [5:0] col_addr;
    logic [4:0] row_addr;
    logic [1:0] bcm_phase;
    logic       mem_bit;
    logic       panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
    logic       panel_clk, panel_lat, panel_oe_n, frame_start;
    logic [4:0] panel_addr;

    int n_pass  = 0;
    int n_total = 0;

    hub75_scan_driver #(
        .BASE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .bcm_phase   (bcm_phase),
        .mem_r1      (mem_bit),
        .mem_g1      (mem_bit),
        .mem_b1      (mem_bit),
        .mem_r2      (mem_bit),
        .mem_g2      (mem_bit),
        .mem_b2      (mem_bit),
        .panel_r1    (panel_r1),
        .panel_g1    (panel_g1),
        .panel_b1    (panel_b1),
        .panel_r2    (panel_r2),
        .panel_g2    (panel_g2),
        .panel_b2    (panel_b2),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe_n  (panel_oe_n),
        .panel_addr  (panel_addr),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel memory: one clock read latency, data = column parity.
    always @(posedge clk) mem_bit <= col_addr[0];

    // Continuous invariants: panel_addr moves only with panel_lat, lat never
    // overlaps a lit panel, and the shift clock is low while latching or lit.
    logic [4:0] prev_addr;
    int viol_addr  = 0;
    int viol_latoe = 0;
    int viol_clk   = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (panel_addr !== prev_addr && panel_lat !== 1'b1) viol_addr <= viol_addr + 1;
            if (panel_lat === 1'b1 && panel_oe_n === 1'b0) viol_latoe <= viol_latoe + 1;
            if (panel_clk === 1'b1 && (panel_lat === 1'b1 || panel_oe_n === 1'b0))
                viol_clk <= viol_clk + 1;
        end
        prev_addr <= panel_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_oe_n"}, {31'd0, panel_oe_n}, 32'd1);
        check({tag, "_others"},
              {5'd0, col_addr, row_addr, bcm_phase,
               panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2,
               panel_clk, panel_lat, panel_addr, frame_start}, 32'd0);
    endtask

    // Watch n clocks and count any sign of activity.
    task automatic idle_watch(input int n, output int fs, output int lats,
                              output int clk_hi, output int oe_low);
        fs = 0; lats = 0; clk_hi = 0; oe_low = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (frame_start !== 1'b0) fs++;
            if (panel_lat !== 1'b0) lats++;
            if (panel_clk !== 1'b0) clk_hi++;
            if (panel_oe_n !== 1'b1) oe_low++;
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        int fs, lats, clk_hi, oe_low;
        idle_watch(n, fs, lats, clk_hi, oe_low);
        check({tag, "_frame_start"}, fs, 0);
        check({tag, "_lat"}, lats, 0);
        check({tag, "_clk"}, clk_hi, 0);
        check({tag, "_oe_low"}, oe_low, 0);
    endtask

    task automatic wait_frame(input int limit, output int cyc, output bit found);
        cyc = 0; found = 1'b0;
        while (!found && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (frame_start === 1'b1) found = 1'b1;
        end
    endtask

    // Observe one plane: from the end of the previous lit run to the end of this one.
    task automatic run_plane(output int edges, output int oe_run, output int lats,
                             output int par_err, output int row_s, output int phase_s,
                             output bit to);
        logic prev_clk, prev_oe;
        bit   done;
        int   cyc;
        edges = 0; oe_run = 0; lats = 0; par_err = 0;
        row_s = -1; phase_s = -1; to = 1'b0; done = 1'b0; cyc = 0;
        prev_clk = panel_clk;
        prev_oe  = panel_oe_n;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (panel_clk === 1'b1 && prev_clk === 1'b0) begin
                if (edges == 0) begin
                    row_s   = int'(row_addr);
                    phase_s = int'(bcm_phase);
                end
                if ({panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2}
                    !== {6{edges[0]}}) par_err++;
                edges++;
            end
            if (panel_lat === 1'b1) lats++;
            if (panel_oe_n === 1'b0) oe_run++;
            if (panel_oe_n === 1'b1 && prev_oe === 1'b0) done = 1'b1;
            prev_clk = panel_clk;
            prev_oe  = panel_oe_n;
            if (cyc > 600) begin
                to   = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    typedef struct {
        int exp_row;
        int exp_phase;
        int exp_oe_run;
        int exp_edges;
        int exp_lats;
        int exp_addr;
    } plane_vec_t;

    plane_vec_t vecs [8];

    initial begin
        int  edges, oe_run, lats, par_err, row_s, phase_s, cyc, run;
        bit  to, found;

        vecs[0] = '{0, 0,  4, 64, 1, 0};
        vecs[1] = '{0, 1,  8, 64, 1, 0};
        vecs[2] = '{0, 2, 16, 64, 1, 0};
        vecs[3] = '{0, 3, 32, 64, 1, 0};
        vecs[4] = '{1, 0,  4, 64, 1, 1};
        vecs[5] = '{1, 1,  8, 64, 1, 1};
        vecs[6] = '{1, 2, 16, 64, 1, 1};
        vecs[7] = '{1, 3, 32, 64, 1, 1};

        // Reset with enable low, then idle for 500 clocks.
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        check_idle("idle500", 500);
        check_reset_values("idle_after_reset");

        // Scan the first two rows plane by plane.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_plane(edges, oe_run, lats, par_err, row_s, phase_s, to);
            check($sformatf("p%0d_timeout", i), {31'd0, to}, 32'd0);
            check($sformatf("p%0d_edges", i), edges, vecs[i].exp_edges);
            check($sformatf("p%0d_pixel_parity", i), par_err, 0);
            check($sformatf("p%0d_lat_pulses", i), lats, vecs[i].exp_lats);
            check($sformatf("p%0d_oe_run", i), oe_run, vecs[i].exp_oe_run);
            check($sformatf("p%0d_row_addr", i), row_s, vecs[i].exp_row);
            check($sformatf("p%0d_bcm_phase", i), phase_s, vecs[i].exp_phase);
            check($sformatf("p%0d_panel_addr", i), {27'd0, panel_addr}, vecs[i].exp_addr);
        end

        // Frame period and row wrap.
        wait_frame(20000, cyc, found);
        check("frame_first_seen", {31'd0, found}, 32'd1);
        wait_frame(20000, cyc, found);
        check("frame_second_seen", {31'd0, found}, 32'd1);
        check("frame_period", cyc, 18688);
        check("wrap_last_addr", {27'd0, panel_addr}, 32'd31);
        check("wrap_row_addr", {27'd0, row_addr}, 32'd0);
        check("wrap_bcm_phase", {30'd0, bcm_phase}, 32'd0);
        run_plane(edges, oe_run, lats, par_err, row_s, phase_s, to);
        check("wrap_plane0_oe_run", oe_run, 4);
        check("wrap_addr_row0", {27'd0, panel_addr}, 32'd0);

        // Drop enable inside the plane-2 lit period.
        run_plane(edges, oe_run, lats, par_err, row_s, phase_s, to);
        check("drop_plane1_oe_run", oe_run, 8);
        cyc = 0;
        while (panel_oe_n !== 1'b0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("drop_reach_display", {31'd0, panel_oe_n}, 32'd0);
        run = 1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (run == 3) enable = 1'b0;
            if (panel_oe_n === 1'b0) run++;
            else cyc = 100;
        end
        check("drop_plane2_oe_run", run, 16);
        check_idle("drop_idle", 300);

        // Reassert: restart at row 0 / plane 0 with frame_start.
        enable = 1'b1;
        wait_frame(5, cyc, found);
        check("restart_frame_start", {31'd0, found}, 32'd1);
        check("restart_row", {27'd0, row_addr}, 32'd0);
        check("restart_phase", {30'd0, bcm_phase}, 32'd0);

        // Reset at SHIFT step 37, where the shift clock is high.
        repeat (37) @(posedge clk);
        #1;
        check("pre_reset_clk_high", {31'd0, panel_clk}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_clk", {31'd0, panel_clk}, 32'd0);
        check_reset_values("midreset");
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_idle("post_reset_idle", 200);
        enable = 1'b1;
        wait_frame(5, cyc, found);
        check("post_reset_start", {31'd0, found}, 32'd1);

        check("inv_addr_only_on_lat", viol_addr, 0);
        check("inv_lat_vs_oe", viol_latoe, 0);
        check("inv_clk_low", viol_clk, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
